// File: rtl/save_state_sequencer.sv
// save_state_sequencer: streams core-state words to or from a save-state controller,
// framed by a header word carrying MAGIC and the word count.
module save_state_sequencer #(
  parameter int          WORDS   = 1024,
  parameter logic [31:0] MAGIC   = 32'h53535631,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        clk_ppu_21_47,
  input  logic        reset_n,
  input  logic        ss_save,
  input  logic        ss_load,
  output logic        ss_req,
  output logic        ss_rnw,
  output logic [25:0] ss_addr,
  output logic [7:0]  ss_be,
  output logic [63:0] ss_dout,
  input  logic [63:0] ss_din,
  input  logic        ss_ack,
  output logic        ss_busy,
  output logic        core_pause,
  output logic [15:0] st_addr,
  output logic        st_rd,
  input  logic [63:0] st_rdata,
  output logic        st_wr,
  output logic [63:0] st_wdata,
  output logic        done,
  output logic        err
);
  localparam logic [16:0] LAST   = 17'(WORDS);
  localparam logic [63:0] HEADER = {MAGIC, 16'h0, LAST[15:0]};
  typedef enum logic [2:0] {
    IDLE, SAVE_FETCH, SAVE_LATCH, SAVE_REQ, SAVE_WAIT_ACK, LOAD_REQ, LOAD_WAIT_ACK, FINISH
  } state_t;
  state_t      state;
  logic [16:0] w;
  logic [15:0] cnt;
  logic        waiting, tmo, bad_hdr, fin, unused_din;
  assign unused_din = ^ss_din[31:16];
  // Any of these ends the operation on this edge, with busy dropping and done pulsing together.
  always_comb begin
    waiting = state == SAVE_WAIT_ACK || state == LOAD_WAIT_ACK;
    tmo     = waiting && !ss_ack && cnt == TIMEOUT - 16'd1;
    bad_hdr = state == LOAD_WAIT_ACK && ss_ack && w == '0 &&
              (ss_din[63:32] != MAGIC || ss_din[15:0] != LAST[15:0]);
    fin     = tmo || bad_hdr || (waiting && ss_ack && w == LAST);
  end
  always_ff @(posedge clk_ppu_21_47 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      w          <= '0;
      cnt        <= '0;
      ss_req     <= 1'b0;
      ss_rnw     <= 1'b0;
      ss_addr    <= '0;
      ss_be      <= '0;
      ss_dout    <= '0;
      ss_busy    <= 1'b0;
      core_pause <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      st_rd      <= 1'b0;
      st_wr      <= 1'b0;
      st_addr    <= '0;
      st_wdata   <= '0;
    end else begin
      ss_req <= 1'b0;
      st_rd  <= 1'b0;
      st_wr  <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: if (ss_save || ss_load) begin
          w          <= '0;
          err        <= 1'b0;
          ss_busy    <= 1'b1;
          core_pause <= 1'b1;
          if (ss_save) ss_dout <= HEADER;
          state <= ss_save ? SAVE_REQ : LOAD_REQ;
        end
        SAVE_FETCH: state <= SAVE_LATCH;
        SAVE_LATCH: begin
          ss_dout <= st_rdata;
          state   <= SAVE_REQ;
        end
        SAVE_REQ, LOAD_REQ: begin
          ss_req  <= 1'b1;
          ss_rnw  <= state == LOAD_REQ;
          ss_addr <= {6'd0, w, 3'b000};
          ss_be   <= 8'hFF;
          cnt     <= '0;
          state   <= state == LOAD_REQ ? LOAD_WAIT_ACK : SAVE_WAIT_ACK;
        end
        SAVE_WAIT_ACK:
          if (!ss_ack) cnt <= cnt + 16'd1;
          else if (!fin) begin
            w       <= w + 17'd1;
            st_rd   <= 1'b1;
            st_addr <= w[15:0];
            state   <= SAVE_FETCH;
          end
        LOAD_WAIT_ACK:
          if (!ss_ack) cnt <= cnt + 16'd1;
          else begin
            if (w != '0) begin
              st_wr    <= 1'b1;
              st_addr  <= 16'(w - 17'd1);
              st_wdata <= ss_din;
            end
            if (!fin) begin
              w     <= w + 17'd1;
              state <= LOAD_REQ;
            end
          end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fin) begin
        ss_busy    <= 1'b0;
        core_pause <= 1'b0;
        done       <= 1'b1;
        state      <= FINISH;
      end
      if (tmo || bad_hdr) err <= 1'b1;
    end
  end
endmodule
